uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop line synchronizer, start/data/stop FSM and a small
// receive FIFO with sticky framing-error and overrun flags.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       sample_tick,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_tick;
    logic             r_frame_err;
    logic             r_overrun;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_rx_s;
    logic w_stop_pt;
    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_full;
    logic w_empty;
    logic w_ferr_set;
    logic w_ovr_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // Stop-bit decision is taken combinationally so the FIFO write lands on
    // the same edge as the sample, making the byte visible one cycle later.
    assign w_stop_pt  = (r_state == STOP) && en && (r_cnt == LAST_CNT);
    assign w_push     = w_stop_pt && w_rx_s;
    assign w_ferr_set = w_stop_pt && !w_rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tick    <= 1'b0;
            r_rx_prev <= 1'b1;
        end else begin
            r_tick    <= 1'b0;
            r_rx_prev <= w_rx_s;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (en && r_rx_prev && !w_rx_s)
                        r_state <= START;
                end
                START: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (r_cnt == MID_CNT) begin
                        r_tick  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_tick  <= 1'b1;
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_tick  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop     = !w_empty && rx_ready;
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)
                r_frame_err <= 1'b1;
            else if (clr_err)
                r_frame_err <= 1'b0;
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
        end
    end

    assign rx_data     = r_mem[r_rd_ptr[AW-1:0]];
    assign rx_valid    = !w_empty;
    assign sample_tick = r_tick;
    assign busy        = (r_state != IDLE);
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 8 clocks per bit with a 4-entry FIFO;
// frames are driven bit-by-bit and results compared against fixed values.
module tb_uart_rx_ctrl;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       sample_tick;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned tick_total = 0;
    int unsigned t0;

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .en         (en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .sample_tick(sample_tick),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (sample_tick === 1'b1)
            tick_total <= tick_total + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; each bit is held for exactly CPB cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            idle(CPB);
        end
        rx_i = stop_bit;
        idle(CPB);
        rx_i = 1'b1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rx_i = 1'b1; en = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
        idle(3);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data",  32'(rx_data),  32'h00);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_tick",  32'(sample_tick), 32'd0);
        chk("rst_ferr",  32'(frame_err), 32'd0);
        chk("rst_ovr",   32'(overrun),   32'd0);
        rst = 1'b1;
        en  = 1'b1;
        idle(4);

        // Good frame 0xA5
        t0 = tick_total;
        send_frame(8'hA5, 1'b1);
        idle(2);
        chk("good_valid", 32'(rx_valid), 32'd1);
        chk("good_data",  32'(rx_data),  32'hA5);
        chk("good_ticks", tick_total - t0, 32'd10);
        chk("good_ferr",  32'(frame_err), 32'd0);
        chk("good_ovr",   32'(overrun),   32'd0);
        chk("good_busy",  32'(busy),      32'd0);
        pop_one();
        chk("good_popped", 32'(rx_valid), 32'd0);

        // Two-cycle glitch on the line
        t0 = tick_total;
        rx_i = 1'b0;
        idle(2);
        rx_i = 1'b1;
        idle(12);
        chk("glitch_ticks", tick_total - t0, 32'd1);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_ferr",  32'(frame_err), 32'd0);
        chk("glitch_busy",  32'(busy),      32'd0);

        // Bad stop bit
        send_frame(8'h3C, 1'b0);
        idle(2);
        chk("bad_ferr",  32'(frame_err), 32'd1);
        chk("bad_valid", 32'(rx_valid),  32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("bad_clr", 32'(frame_err), 32'd0);
        idle(4);

        // Overrun with five frames and no consumer
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 1'b1);
        idle(2);
        chk("ovr_flag",  32'(overrun),  32'd1);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr_drain%0d", i), 32'(rx_data), 32'(i));
            pop_one();
        end
        chk("ovr_empty", 32'(rx_valid), 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        idle(4);

        // Full FIFO with a pop in the same cycle as the push
        for (int i = 1; i <= 4; i++)
            send_frame(8'(i), 1'b1);
        idle(1);
        chk("full_ovr0", 32'(overrun), 32'd0);
        chk("full_head", 32'(rx_data), 32'h01);
        fork
            send_frame(8'h05, 1'b1);
            begin
                idle(78);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        idle(2);
        chk("pp_ovr", 32'(overrun), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pp_drain%0d", i), 32'(rx_data), 32'(i));
            pop_one();
        end
        chk("pp_empty", 32'(rx_valid), 32'd0);
        idle(4);

        // Abort with en=0 during DATA
        t0 = tick_total;
        rx_i = 1'b0;
        idle(CPB + 12);
        chk("abort_busy1", 32'(busy), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy0", 32'(busy), 32'd0);
        rx_i = 1'b1;
        idle(10);
        en = 1'b1;
        idle(80);
        chk("abort_ticks", tick_total - t0, 32'd2);
        chk("abort_valid", 32'(rx_valid),   32'd0);
        chk("abort_ferr",  32'(frame_err),  32'd0);

        // Reset mid-frame with a byte already queued
        send_frame(8'h77, 1'b1);
        idle(2);
        chk("pre_rst_valid", 32'(rx_valid), 32'd1);
        rx_i = 1'b0;
        idle(30);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_data",  32'(rx_data),  32'h00);
        rx_i = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(5);
        chk("post_rst_busy", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1);
        idle(2);
        chk("post_valid", 32'(rx_valid),  32'd1);
        chk("post_data",  32'(rx_data),   32'h5A);
        chk("post_ferr",  32'(frame_err), 32'd0);
        chk("post_ovr",   32'(overrun),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
